// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: RAS request opcodes, controller states and
// the checkpoint record layout.
package riscv_pkg;

  typedef enum logic [1:0] {
    RAS_NONE          = 2'd0,
    RAS_POP           = 2'd1,
    RAS_PUSH          = 2'd2,
    RAS_POP_THEN_PUSH = 2'd3
  } ras_op_t;

  typedef enum logic [1:0] {
    RAS_RUN     = 2'd0,
    RAS_RESTORE = 2'd1,
    RAS_FLUSH   = 2'd2
  } ras_ctrl_state_t;

  localparam int RAS_DEF_ADDR_W = 64;
  localparam int RAS_DEF_PTR_W  = 4;

  // Checkpoint layout for the default 64-bit / 16-entry configuration.
  typedef struct packed {
    logic [RAS_DEF_PTR_W-1:0]  tos;
    logic [RAS_DEF_PTR_W:0]    count;
    logic [RAS_DEF_ADDR_W-1:0] top_addr;
  } ras_ckpt_t;

endpackage

// File: rtl/riscv_ras_ckpt_fifo.sv
// Checkpoint FIFO for the RAS: one slot per in-flight predicted branch,
// freed in order from head, rewound at tail on mispredict.
module riscv_ras_ckpt_fifo #(
  parameter int DATA_W = 73,
  parameter int DEPTH  = 4,
  localparam int ID_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_alloc,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_free,
  input  logic              i_restore,
  input  logic [ID_W-1:0]   i_restore_id,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ID_W-1:0]   o_tail,
  output logic              o_full,
  output logic              o_live
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ID_W-1:0]   r_head;
  logic [ID_W-1:0]   r_tail;
  logic [ID_W:0]     r_fill;
  logic [ID_W-1:0]   w_age;
  logic              w_free;

  // Age of the requested id relative to the oldest live slot.
  assign w_age     = i_restore_id - r_head;
  assign o_live    = {1'b0, w_age} < r_fill;
  assign o_full    = r_fill == (ID_W+1)'(DEPTH);
  assign o_tail    = r_tail;
  assign o_rd_data = r_mem[i_restore_id];
  assign w_free    = i_free && (r_fill != '0);

  always_ff @(posedge clk) begin
    if (i_alloc) r_mem[r_tail] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
    end else if (i_restore) begin
      r_tail <= i_restore_id + 1'b1;
      r_fill <= {1'b0, w_age} + 1'b1;
    end else begin
      if (i_alloc) r_tail <= r_tail + 1'b1;
      if (w_free)  r_head <= r_head + 1'b1;
      case ({i_alloc, w_free})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/riscv_ras_ctrl.sv
// Speculative return-address stack: circular storage, POP/PUSH sequencing,
// checkpoint restore on mispredict and flush on abort.
module riscv_ras_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int RAS_DEPTH  = 16,
  parameter int CKPT_DEPTH = 4,
  localparam int PTR_W     = $clog2(RAS_DEPTH),
  localparam int ID_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  i_req_valid,
  input  logic [1:0]            i_req_op,
  input  logic [ADDR_WIDTH-1:0] i_push_addr,
  output logic                  o_req_ready,
  output logic                  o_top_valid,
  output logic [ADDR_WIDTH-1:0] o_top_addr,
  output logic [PTR_W:0]        o_count,
  input  logic                  i_ckpt_alloc,
  output logic                  o_ckpt_ready,
  output logic [ID_W-1:0]       o_ckpt_id,
  input  logic                  i_ckpt_free,
  input  logic                  i_restore,
  input  logic [ID_W-1:0]       i_restore_id,
  input  logic                  i_flush,
  output logic                  o_underflow,
  output logic                  o_restore_err,
  output logic [1:0]            o_fsm_status
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_RESTORE = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  typedef struct packed {
    logic [PTR_W-1:0]      tos;
    logic [PTR_W:0]        count;
    logic [ADDR_WIDTH-1:0] top_addr;
  } ckpt_t;

  logic [ADDR_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      r_tos;
  logic [PTR_W:0]        r_count;
  logic [1:0]            r_state;
  logic                  r_underflow;
  logic                  r_restore_err;
  ckpt_t                 r_cap;

  logic                  w_run, w_empty, w_acc, w_alloc, w_free;
  logic                  w_rst_go, w_rst_bad, w_clear, w_restore_wr;
  logic                  w_full, w_live;
  logic [PTR_W-1:0]      w_tos_inc, w_tos_dec;
  logic [ADDR_WIDTH-1:0] w_mem_top;
  ckpt_t                 w_snap, w_rd_ckpt;
  logic                  w_we;
  logic [PTR_W-1:0]      w_waddr;
  logic [ADDR_WIDTH-1:0] w_wdata;

  assign w_run     = r_state == ST_RUN;
  assign w_empty   = r_count == '0;
  assign w_tos_inc = r_tos + 1'b1;
  assign w_tos_dec = r_tos - 1'b1;
  assign w_mem_top = r_mem[r_tos];

  assign o_req_ready   = enable && w_run && !i_restore && !i_flush;
  assign o_ckpt_ready  = enable && w_run && !w_full;
  assign o_top_valid   = !w_empty;
  assign o_top_addr    = w_empty ? '0 : w_mem_top;
  assign o_count       = r_count;
  assign o_underflow   = r_underflow;
  assign o_restore_err = r_restore_err;
  assign o_fsm_status  = r_state;

  // Flush beats restore, restore beats alloc/free/request.
  assign w_acc        = i_req_valid && o_req_ready;
  assign w_alloc      = i_ckpt_alloc && o_ckpt_ready && !i_flush && !i_restore;
  assign w_free       = i_ckpt_free && enable && w_run && !i_flush && !i_restore;
  assign w_rst_go     = enable && w_run && !i_flush && i_restore && w_live;
  assign w_rst_bad    = enable && w_run && !i_flush && i_restore && !w_live;
  assign w_clear      = enable && (r_state == ST_FLUSH);
  assign w_restore_wr = enable && !reset && (r_state == ST_RESTORE);

  assign w_snap = '{tos: r_tos, count: r_count, top_addr: w_mem_top};

  riscv_ras_ckpt_fifo #(
    .DATA_W ($bits(ckpt_t)),
    .DEPTH  (CKPT_DEPTH)
  ) u_ckpt (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_alloc      (w_alloc),
    .i_wdata      (w_snap),
    .i_free       (w_free),
    .i_restore    (w_rst_go),
    .i_restore_id (i_restore_id),
    .o_rd_data    (w_rd_ckpt),
    .o_tail       (o_ckpt_id),
    .o_full       (w_full),
    .o_live       (w_live)
  );

  // Single stack write port: restore rewrites the saved top, else requests.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_tos;
    w_wdata = i_push_addr;
    if (w_restore_wr) begin
      w_we    = 1'b1;
      w_waddr = r_cap.tos;
      w_wdata = r_cap.top_addr;
    end else if (w_acc) begin
      case (ras_op_t'(i_req_op))
        RAS_PUSH: begin
          w_we    = 1'b1;
          w_waddr = w_tos_inc;
        end
        RAS_POP_THEN_PUSH: begin
          w_we    = 1'b1;
          w_waddr = w_empty ? w_tos_inc : r_tos;
        end
        default: w_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_tos         <= '0;
      r_count       <= '0;
      r_underflow   <= 1'b0;
      r_restore_err <= 1'b0;
    end else if (enable) begin
      r_underflow   <= 1'b0;
      r_restore_err <= w_rst_bad;
      case (r_state)
        ST_RUN: begin
          if (i_flush) begin
            r_state <= ST_FLUSH;
          end else if (w_rst_go) begin
            r_state <= ST_RESTORE;
            r_cap   <= w_rd_ckpt;
          end else if (w_acc) begin
            case (ras_op_t'(i_req_op))
              RAS_PUSH: begin
                r_tos <= w_tos_inc;
                if (r_count != (PTR_W+1)'(RAS_DEPTH)) r_count <= r_count + 1'b1;
              end
              RAS_POP: begin
                if (w_empty) begin
                  r_underflow <= 1'b1;
                end else begin
                  r_tos   <= w_tos_dec;
                  r_count <= r_count - 1'b1;
                end
              end
              RAS_POP_THEN_PUSH: begin
                if (w_empty) begin
                  r_tos   <= w_tos_inc;
                  r_count <= r_count + 1'b1;
                end
              end
              default: r_tos <= r_tos;
            endcase
          end
        end
        ST_RESTORE: begin
          r_tos   <= r_cap.tos;
          r_count <= r_cap.count;
          r_state <= ST_RUN;
        end
        ST_FLUSH: begin
          r_tos   <= '0;
          r_count <= '0;
          r_state <= ST_RUN;
        end
        default: r_state <= ST_FLUSH;
      endcase
    end
  end

endmodule
